// File: rtl/mux_scan_reg.sv
// rtl/mux_scan_reg.sv - registered N-channel word mux with manual select and masked round-robin scan
//
// Purpose:
//   Picks one of CHANNELS input words and registers it onto dout, together
//   with the channel index it came from. Two operating modes:
//     - manual: the channel is chosen by sel (out-of-range selects ignored)
//     - scan:   channels marked eligible in mask are visited round-robin,
//               each held for DWELL cycles before moving on
//   With en low the block idles: outputs freeze and ch_valid drops.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   din        packed channel words, channel k = din[k*WIDTH +: WIDTH]
//   sel        manual channel select
//   mode       0 = manual, 1 = scan
//   en         block enable
//   mask       per-channel scan eligibility (1 = eligible)
//   dout       registered selected word
//   cur_ch     channel index dout was taken from (always aligned with dout)
//   ch_valid   dout holds a live sample
//   ch_changed one-cycle pulse on the cycle cur_ch takes a new value
module mux_scan_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       mask,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      ch_valid,
  output logic                      ch_changed
);

  localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ch_valid_q, ch_valid_d;
  logic             ch_changed_q, ch_changed_d;

  logic [SEL_W-1:0] ch_next;
  logic [SEL_W-1:0] scan_next;
  logic             sel_in_range;
  logic             cur_eligible;
  logic             any_eligible;
  logic             load_dout;

  logic [WIDTH-1:0] din_ch [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign din_ch[k] = din[k*WIDTH +: WIDTH];
  end

  // First eligible channel strictly after 'from', wrapping modulo CHANNELS.
  // The search ends on 'from' itself, so a lone eligible channel re-selects
  // itself. Offsets are walked far-to-near so the nearest hit is written last
  // and wins; the wrap is an explicit subtract so CHANNELS need not be 2^n.
  function automatic logic [SEL_W-1:0] next_eligible(
    input logic [SEL_W-1:0]    from,
    input logic [CHANNELS-1:0] elig
  );
    logic [SEL_W-1:0] pick;
    int               idx;
    pick = from;
    for (int off = CHANNELS; off >= 1; off--) begin
      idx = int'(from) + off;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (elig[idx[SEL_W-1:0]]) begin
        pick = idx[SEL_W-1:0];
      end
    end
    return pick;
  endfunction

  assign sel_in_range = (int'(sel) < CHANNELS);
  assign cur_eligible = mask[cur_ch_q];
  assign any_eligible = |mask;
  assign scan_next    = next_eligible(cur_ch_q, mask);

  // State is a pure function of en/mode at each edge.
  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      state_d = mode ? ST_SCAN : ST_MANUAL;
    end
  end

  // Channel choice and dwell counting for the state being entered this edge.
  always_comb begin
    ch_next    = cur_ch_q;
    cnt_d      = '0;
    ch_valid_d = 1'b0;
    load_dout  = 1'b0;
    unique case (state_d)
      ST_IDLE: begin
      end
      ST_MANUAL: begin
        ch_valid_d = 1'b1;
        load_dout  = 1'b1;
        if (sel_in_range) begin
          ch_next = sel;
        end
      end
      ST_SCAN: begin
        // With nothing eligible everything holds and the counter stays clear.
        if (any_eligible) begin
          ch_valid_d = 1'b1;
          load_dout  = 1'b1;
          if (state_q != ST_SCAN) begin
            // Fresh entry: keep the current channel when it is eligible.
            if (!cur_eligible) begin
              ch_next = scan_next;
            end
          end else if (!cur_eligible || (cnt_q == CNT_LAST)) begin
            // Dwell expired, or the current channel was masked out mid-dwell.
            ch_next = scan_next;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    cur_ch_d     = ch_next;
    dout_d       = load_dout ? din_ch[ch_next] : dout_q;
    ch_changed_d = (ch_next != cur_ch_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cur_ch_q     <= '0;
      dout_q       <= '0;
      ch_valid_q   <= 1'b0;
      ch_changed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_ch_q     <= cur_ch_d;
      dout_q       <= dout_d;
      ch_valid_q   <= ch_valid_d;
      ch_changed_q <= ch_changed_d;
    end
  end

  assign dout       = dout_q;
  assign cur_ch     = cur_ch_q;
  assign ch_valid   = ch_valid_q;
  assign ch_changed = ch_changed_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb/tb_mux_scan_reg.sv - self-checking bench for mux_scan_reg
module tb_mux_scan_reg;

  localparam int W  = 8;
  localparam int CH = 8;
  localparam int SW = 3;
  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [CH*W-1:0] din;
  logic [SW-1:0]   sel;
  logic            mode;
  logic            en;
  logic [CH-1:0]   mask;
  logic [W-1:0]    dout;
  logic [SW-1:0]   cur_ch;
  logic            ch_valid;
  logic            ch_changed;

  logic [6*W-1:0]  din6;
  logic [SW-1:0]   sel6;
  logic            mode6;
  logic            en6;
  logic [5:0]      mask6;
  logic [W-1:0]    dout6;
  logic [SW-1:0]   cur_ch6;
  logic            ch_valid6;
  logic            ch_changed6;

  int checks = 0;
  int errors = 0;

  mux_scan_reg #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode), .en(en),
    .mask(mask), .dout(dout), .cur_ch(cur_ch), .ch_valid(ch_valid),
    .ch_changed(ch_changed)
  );

  mux_scan_reg #(.WIDTH(W), .CHANNELS(6), .SEL_W(SW), .DWELL(DW)) dut6 (
    .clk(clk), .rst_n(rst_n), .din(din6), .sel(sel6), .mode(mode6), .en(en6),
    .mask(mask6), .dout(dout6), .cur_ch(cur_ch6), .ch_valid(ch_valid6),
    .ch_changed(ch_changed6)
  );

  // Reference model: 'held' is how many cycles the current channel has been
  // on the output within its present dwell (1..DW).
  typedef struct {
    int         st;
    int         cur;
    int         held;
    logic [W-1:0] dout;
    logic       valid;
    logic       changed;
  } mdl_t;

  mdl_t mdl;

  function automatic int first_after(int c, logic [CH-1:0] mk);
    for (int k = 1; k <= CH; k++) begin
      if (((mk >> ((c + k) % CH)) & 1) != 0) return (c + k) % CH;
    end
    return c;
  endfunction

  function automatic logic [W-1:0] word_of(logic [CH*W-1:0] d, int c);
    logic [CH*W-1:0] t;
    t = d >> (c * W);
    return t[W-1:0];
  endfunction

  function automatic mdl_t model_next(mdl_t s, logic r, logic e, logic md,
                                      logic [SW-1:0] sl, logic [CH-1:0] mk,
                                      logic [CH*W-1:0] d);
    mdl_t n;
    int   want;
    int   nxt;
    logic cur_ok;
    n = s;
    if (!r) begin
      n.st = 0; n.cur = 0; n.held = 0; n.dout = '0; n.valid = 1'b0; n.changed = 1'b0;
      return n;
    end
    want   = !e ? 0 : (md ? 2 : 1);
    nxt    = s.cur;
    cur_ok = (((mk >> s.cur) & 1) != 0);
    if (want == 0) begin
      n.valid = 1'b0;
      n.held  = 0;
    end else if (want == 1) begin
      if (int'(sl) < CH) nxt = int'(sl);
      n.valid = 1'b1;
      n.held  = 0;
      n.dout  = word_of(d, nxt);
    end else if (mk == '0) begin
      n.valid = 1'b0;
      n.held  = 1;
    end else begin
      n.valid = 1'b1;
      if (s.st != 2) begin
        nxt    = cur_ok ? s.cur : first_after(s.cur, mk);
        n.held = 1;
      end else if (!cur_ok || s.held >= DW) begin
        nxt    = first_after(s.cur, mk);
        n.held = 1;
      end else begin
        n.held = s.held + 1;
      end
      n.dout = word_of(d, nxt);
    end
    n.changed = (nxt != s.cur);
    n.cur     = nxt;
    n.st      = want;
    return n;
  endfunction

  always @(posedge clk) begin
    mdl <= model_next(mdl, rst_n, en, mode, sel, mask, din);
  end

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; mask = '1; sel = '0;
    din = '0;
    for (int k = 0; k < CH; k++) din = din | ((CH*W)'(k + 'h10) << (k * W));
    din6 = '0;
    for (int k = 0; k < 6; k++) din6 = din6 | ((6*W)'(k + 'h20) << (k * W));
    sel6 = '0; mode6 = 1'b0; en6 = 1'b0; mask6 = '0;
    repeat (2) @(negedge clk);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if (cur_ch !== 3'd0) begin errors++; $display("FAIL reset_cur_ch got %0d exp 0", cur_ch); end
    checks++; if (ch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ch_valid); end
    checks++; if (ch_changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %b exp 0", ch_changed); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (dout !== 8'h10) begin errors++; $display("FAIL release_dout got %h exp 10", dout); end
    checks++; if (ch_valid !== 1'b1) begin errors++; $display("FAIL release_valid got %b exp 1", ch_valid); end
    checks++; if (ch_changed !== 1'b0) begin errors++; $display("FAIL release_changed got %b exp 0", ch_changed); end
  endtask

  task automatic test_manual();
    mode = 1'b0; sel = 3'd5;
    @(negedge clk);
    checks++; if (dout !== 8'h15) begin errors++; $display("FAIL manual_dout got %h exp 15", dout); end
    checks++; if (cur_ch !== 3'd5) begin errors++; $display("FAIL manual_cur got %0d exp 5", cur_ch); end
    checks++; if (ch_changed !== 1'b1) begin errors++; $display("FAIL manual_chg got %b exp 1", ch_changed); end
    @(negedge clk);
    checks++; if (ch_changed !== 1'b0) begin errors++; $display("FAIL manual_chg_pulse got %b exp 0", ch_changed); end
    din[5*W +: W] = 8'hAA;
    @(negedge clk);
    checks++; if (dout !== 8'hAA) begin errors++; $display("FAIL manual_resample got %h exp aa", dout); end
  endtask

  task automatic test_scan_wrap();
    int exp_seq [13] = '{0, 0, 0, 0, 2, 2, 2, 2, 7, 7, 7, 7, 0};
    logic exp_chg;
    sel = 3'd0;
    @(negedge clk);
    mode = 1'b1; mask = 8'b1000_0101;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      exp_chg = (i == 4 || i == 8 || i == 12);
      checks++; if (int'(cur_ch) !== exp_seq[i]) begin errors++; $display("FAIL scan_cur[%0d] got %0d exp %0d", i, cur_ch, exp_seq[i]); end
      checks++; if (dout !== 8'(8'h10 + exp_seq[i])) begin errors++; $display("FAIL scan_dout[%0d] got %h exp %h", i, dout, 8'(8'h10 + exp_seq[i])); end
      checks++; if (ch_changed !== exp_chg) begin errors++; $display("FAIL scan_chg[%0d] got %b exp %b", i, ch_changed, exp_chg); end
    end
  endtask

  task automatic test_mask_remove();
    repeat (4) @(negedge clk);
    checks++; if (cur_ch !== 3'd2) begin errors++; $display("FAIL rm_enter got %0d exp 2", cur_ch); end
    @(negedge clk);
    mask = 8'b1000_0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (int'(cur_ch) !== ((i < 4) ? 7 : 0)) begin errors++; $display("FAIL rm_cur[%0d] got %0d exp %0d", i, cur_ch, (i < 4) ? 7 : 0); end
    end
  endtask

  task automatic test_all_masked();
    mask = '0;
    @(negedge clk);
    checks++; if (ch_valid !== 1'b0) begin errors++; $display("FAIL masked_valid got %b exp 0", ch_valid); end
    checks++; if (dout !== 8'h10) begin errors++; $display("FAIL masked_dout got %h exp 10", dout); end
    din[0 +: W] = 8'h55;
    @(negedge clk);
    checks++; if (dout !== 8'h10) begin errors++; $display("FAIL masked_hold got %h exp 10", dout); end
    mask = 8'b0000_1000;
    @(negedge clk);
    checks++; if (cur_ch !== 3'd3) begin errors++; $display("FAIL unmask_cur got %0d exp 3", cur_ch); end
    checks++; if (ch_valid !== 1'b1) begin errors++; $display("FAIL unmask_valid got %b exp 1", ch_valid); end
    checks++; if (dout !== 8'h13) begin errors++; $display("FAIL unmask_dout got %h exp 13", dout); end
    en = 1'b0; din[3*W +: W] = 8'h66;
    repeat (2) @(negedge clk);
    checks++; if (ch_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", ch_valid); end
    checks++; if (dout !== 8'h13) begin errors++; $display("FAIL idle_dout got %h exp 13", dout); end
    checks++; if (ch_changed !== 1'b0) begin errors++; $display("FAIL idle_chg got %b exp 0", ch_changed); end
  endtask

  task automatic test_mode_switch();
    en = 1'b1; mode = 1'b1; mask = '1;
    repeat (2) @(negedge clk);
    mode = 1'b0; sel = 3'd3;
    @(negedge clk);
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (int'(cur_ch) !== ((i < 4) ? 3 : 4)) begin errors++; $display("FAIL switch_cur[%0d] got %0d exp %0d", i, cur_ch, (i < 4) ? 3 : 4); end
    end
  endtask

  task automatic test_out_of_range();
    en6 = 1'b1; mode6 = 1'b0; sel6 = 3'd2;
    @(negedge clk);
    checks++; if (cur_ch6 !== 3'd2 || dout6 !== 8'h22) begin errors++; $display("FAIL oor_base got %0d/%h exp 2/22", cur_ch6, dout6); end
    sel6 = 3'd7; din6[2*W +: W] = 8'h99;
    @(negedge clk);
    checks++; if (cur_ch6 !== 3'd2) begin errors++; $display("FAIL oor_sel7 got %0d exp 2", cur_ch6); end
    checks++; if (dout6 !== 8'h99 || ch_changed6 !== 1'b0) begin errors++; $display("FAIL oor_resample got %h/%b exp 99/0", dout6, ch_changed6); end
    sel6 = 3'd6;
    @(negedge clk);
    checks++; if (cur_ch6 !== 3'd2) begin errors++; $display("FAIL oor_sel6 got %0d exp 2", cur_ch6); end
    sel6 = 3'd5;
    @(negedge clk);
    mode6 = 1'b1; mask6 = 6'b10_0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (int'(cur_ch6) !== ((i < 4) ? 5 : 0)) begin errors++; $display("FAIL wrap6_cur[%0d] got %0d exp %0d", i, cur_ch6, (i < 4) ? 5 : 0); end
    end
    checks++; if (ch_changed6 !== 1'b1) begin errors++; $display("FAIL wrap6_chg got %b exp 1", ch_changed6); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(59) != 0);
      en    = ($urandom_range(9) != 0);
      mode  = ($urandom_range(9) < 7);
      sel   = SW'($urandom_range(7));
      r     = $urandom_range(7);
      if (r == 0)      mask = '0;
      else if (r == 1) mask = CH'(1) << $urandom_range(CH - 1);
      else             mask = CH'($urandom);
      if ($urandom_range(3) == 0) din = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (dout !== mdl.dout || int'(cur_ch) !== mdl.cur || ch_valid !== mdl.valid || ch_changed !== mdl.changed) begin
        errors++;
        $display("FAIL random[%0d] got d=%h c=%0d v=%b x=%b exp d=%h c=%0d v=%b x=%b",
                 i, dout, cur_ch, ch_valid, ch_changed, mdl.dout, mdl.cur, mdl.valid, mdl.changed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_wrap();
    test_mask_remove();
    test_all_masked();
    test_mode_switch();
    test_out_of_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
